// File: rtl/x_top_uart_pkg.sv
// Shared UART types and defaults.
// Build option X_TOP_UART_RX_FIFO_OVERWRITE_EN: when defined, a full rx FIFO overwrites its oldest byte instead of dropping the newest.
package x_top_uart_pkg;

  typedef logic [7:0] x_uart_byte_t;

  localparam int C_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/x_top_uart_rx_fifo_ram.sv
// Register array storage: p_depth x p_width, one synchronous write port and one asynchronous read port.
// Read data follows i_raddr in the same cycle; there is no backpressure and every write is accepted.
module x_top_uart_rx_fifo_ram
  import x_top_uart_pkg::*;
#(
  parameter int p_depth = C_RX_FIFO_DEPTH,
  parameter int p_width = $bits(x_uart_byte_t)
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(p_depth)-1:0] i_waddr,
  input  logic [p_width-1:0]         i_wdata,
  input  logic [$clog2(p_depth)-1:0] i_raddr,
  output logic [p_width-1:0]         o_rdata
);

  logic [p_width-1:0] mem [p_depth];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/x_top_uart_rx_fifo.sv
// UART rx byte buffer: captures every receiver strobe; a byte is visible on o_valid/o_data one cycle after its strobe.
// The receiver cannot be stalled: a full FIFO loses a byte and sets sticky o_overflow (X_TOP_UART_RX_FIFO_OVERWRITE_EN selects drop-oldest).
module x_top_uart_rx_fifo
  import x_top_uart_pkg::*;
#(
  parameter int p_depth = C_RX_FIFO_DEPTH,
  parameter int p_width = $bits(x_uart_byte_t)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [p_width-1:0]       i_data,
  output logic                     o_valid,
  output logic [p_width-1:0]       o_data,
  input  logic                     i_accept,
  output logic [$clog2(p_depth):0] o_level,
  output logic                     o_full,
  output logic                     o_overflow,
  input  logic                     i_clr_overflow
);

  localparam int c_aw = $clog2(p_depth);
  localparam logic [c_aw:0] c_one = {{c_aw{1'b0}}, 1'b1};

  logic [c_aw:0]      wr_ptr, rd_ptr;
  logic               empty, full, pop, push, lost, wr_en, rd_adv;
  logic [p_width-1:0] rd_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[c_aw-1:0] == rd_ptr[c_aw-1:0]) && (wr_ptr[c_aw] != rd_ptr[c_aw]);
  assign pop   = !empty && i_accept;
  assign push  = i_valid && (!full || pop);
  assign lost  = i_valid && full && !pop;

`ifdef X_TOP_UART_RX_FIFO_OVERWRITE_EN
  // Lost byte lands in the oldest slot; advancing both pointers keeps the level at p_depth.
  assign wr_en  = push || lost;
  assign rd_adv = pop || lost;
`else
  assign wr_en  = push;
  assign rd_adv = pop;
`endif

  x_top_uart_rx_fifo_ram #(
    .p_depth (p_depth),
    .p_width (p_width)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_en),
    .i_waddr (wr_ptr[c_aw-1:0]),
    .i_wdata (i_data),
    .i_raddr (rd_ptr[c_aw-1:0]),
    .o_rdata (rd_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + c_one;
      if (rd_adv) rd_ptr <= rd_ptr + c_one;
      // A loss in the same cycle as a clear keeps the flag set.
      if (lost)                o_overflow <= 1'b1;
      else if (i_clr_overflow) o_overflow <= 1'b0;
    end
  end

  assign o_valid = !empty;
  assign o_data  = empty ? '0 : rd_data;
  assign o_level = wr_ptr - rd_ptr;
  assign o_full  = full;

endmodule

// File: doc/x_top_uart_rx_fifo.md
Name: x_top_uart_rx_fifo

Overview:
Receive buffer that sits directly downstream of the UART receiver (x_top_uart_rx).
- The receiver emits one-cycle byte strobes and cannot be stalled. This block captures every strobe into a circular FIFO.
- It re-presents the bytes on a valid/accept handshake to the bus-side consumer (peripheral register block or CPU read path).
- It tracks occupancy and flags lost bytes with a sticky overflow bit.

Parameters:
p_depth, 16, number of entries; power of two, >= 2
p_width, 8, data width in bits (byte from the receiver)

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous, active-high reset
i_valid  input  1  one-cycle strobe from the receiver; a byte is present on i_data
i_data  input  p_width  received byte; sampled only when i_valid=1
o_valid  output  1  FIFO is non-empty; o_data holds the head byte
o_data  output  p_width  head-of-FIFO byte
i_accept  input  1  consumer pops the head; effective only when o_valid=1
o_level  output  $clog2(p_depth)+1  current occupancy, 0..p_depth
o_full  output  1  o_level == p_depth
o_overflow  output  1  sticky: at least one byte was lost
i_clr_overflow  input  1  one-cycle pulse that clears o_overflow

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is asynchronous and active-high. All state is cleared immediately when i_rst asserts.
- Reset values: o_valid=0, o_level=0, o_full=0, o_overflow=0. o_data = 0, because the storage contents are don't-care but the output is masked to 0 while empty.
- Pointers: write pointer wr_ptr and read pointer rd_ptr, each $clog2(p_depth)+1 bits. Each increments modulo 2*p_depth. Index = low bits.
  - empty: wr_ptr == rd_ptr
  - full: low bits equal and MSBs differ
- o_level = wr_ptr - rd_ptr, computed modulo 2*p_depth. It is registered or derived from the registered pointers, never from inputs.
- Push condition: i_valid && (!full || pop).
- Pop condition: o_valid && i_accept.
- Push timing: a push in cycle N stores i_data at mem[wr_ptr], and wr_ptr increments at the edge ending cycle N.
- Latency: byte strobed in cycle N gives o_valid=1 with that byte in cycle N+1 (when the FIFO was empty).
- No combinational bypass: i_valid with an empty FIFO and i_accept=1 in the same cycle does not pop.
- A pop advances rd_ptr at the clock edge. o_data reflects the new head in the next cycle.
- o_valid, o_data, o_level and o_full depend only on registered state; there are no combinational paths from inputs.
- Simultaneous push and pop:
  - Both take effect and o_level is unchanged.
  - This applies when full, because the pop frees the slot that the push fills.
  - It also applies when o_level==1: the new byte becomes the head next cycle, with no bubble.
- i_accept while o_valid=0: ignored, no pointer change.
- Full with i_valid and no pop: handled per the optional feature below. o_overflow is set at the next edge in every configuration.
- Overflow flag:
  - Set on any lost byte and held until i_clr_overflow.
  - If set and clear occur in the same cycle, set wins and o_overflow stays 1.
- Pointer wrap: correct across unlimited wrap-arounds. Wrap is tested at p_depth=2 and p_depth=16.
- Reset mid-operation: pointers and flag clear immediately, and the in-flight byte is discarded. The receiver keeps running; strobes during reset are ignored.

Optional Feature:
Macro: X_TOP_UART_RX_FIFO_OVERWRITE_EN
- Undefined (default), drop-newest: a byte arriving when the FIFO is full with no pop is discarded. Pointers are unchanged and o_overflow is set.
- Defined, overwrite-oldest: a byte arriving when the FIFO is full with no pop is written at wr_ptr (the oldest slot).
  - wr_ptr and rd_ptr both increment, so o_level stays p_depth.
  - The head becomes the next-oldest byte.
  - o_overflow is set.

Decomposition:
- Shared package x_top_uart_pkg holds:
  - typedef x_uart_byte_t (logic [7:0])
  - constant for default FIFO depth (16)
  - the macro name, documented alongside
- One sub-module, x_top_uart_rx_fifo_ram: a p_depth x p_width register array with one synchronous write port and one asynchronous read port.
- Pointer, flag and level logic stay in the top.

Test Plan:
- Single byte: reset, then i_valid with 0xA5 at cycle 5 -> o_valid=1, o_data=0xA5, o_level=1 at cycle 6. Then i_accept=1 -> o_valid=0, o_level=0 at cycle 7.
- Fill and drain: 16 strobes 0x00..0x0F with no accept -> o_full=1, o_level=16, o_overflow=0. Then drain with i_accept held -> bytes 0x00..0x0F in order, one per cycle, then o_valid=0.
- Overflow, default build: fill with 0x00..0x0F, then strobe 0xEE -> o_overflow=1, o_level=16, drained sequence 0x00..0x0F. i_clr_overflow pulse -> o_overflow=0 next cycle.
- Overflow with X_TOP_UART_RX_FIFO_OVERWRITE_EN defined: same stimulus -> drained sequence 0x01..0x0F followed by 0xEE, and o_overflow=1.
- Simultaneous push/pop: full at level 16, i_valid=0x55 and i_accept=1 in the same cycle -> o_level stays 16, o_overflow=0, 0x55 is drained last. Same-cycle overflow set and i_clr_overflow -> o_overflow=1.
- Wrap and reset: p_depth=2, 1000 random push/pop cycles against a scoreboard -> no mismatch. Assert i_rst mid-stream -> o_valid, o_level, o_overflow go to 0 immediately, without waiting for a clock edge.
